// File: rtl/sc_game_pkg.sv
// Shared game constants: FSM state encodings, speed-level geometry and
// default divider tuning for the velocity tick path.
package sc_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CRASH = 2'b10
  } sc_state_e;

  localparam int LEVEL_WIDTH = 3;
  localparam int LEVEL_MAX   = (1 << LEVEL_WIDTH) - 1;

  localparam int STEP_WIDTH         = 22;
  localparam int STEP_BASE_DEFAULT  = 2_000_000;
  localparam int STEP_DEC_DEFAULT   = 250_000;
  localparam int LOCK_TICKS_DEFAULT = 3;

endpackage

// File: rtl/sc_step_divider.sv
// Road-scroll step divider: counts 0..period-1 and emits a registered
// one-cycle pulse on wrap. Clear or disable parks the count at zero.
module sc_step_divider #(
  parameter int STEP_WIDTH = 22
) (
  input  logic                  SC_COUNTER_CLOCK_50,
  input  logic                  SC_COUNTER_RESET_InLow,
  input  logic [STEP_WIDTH-1:0] period,
  input  logic                  enable,
  input  logic                  clear,
  output logic                  step
);

  logic [STEP_WIDTH-1:0] count_reg, count_next;
  logic                  step_reg, step_next;

  always_comb begin
    count_next = count_reg + STEP_WIDTH'(1);
    step_next  = 1'b0;
    if (clear || !enable) begin
      count_next = '0;
    end else if (count_reg == period - STEP_WIDTH'(1)) begin
      count_next = '0;
      step_next  = 1'b1;
    end
  end

  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      count_reg <= '0;
      step_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      step_reg  <= step_next;
    end
  end

  assign step = step_reg;

endmodule

// File: rtl/sc_speed_governor.sv
// Player-car speed governor: steps the speed level on velocity ticks, drives the
// velocity counter's clear input, and handles start and crash lockout.
module sc_speed_governor #(
  parameter int LEVEL_WIDTH = sc_game_pkg::LEVEL_WIDTH,
  parameter int STEP_WIDTH  = sc_game_pkg::STEP_WIDTH,
  parameter int STEP_BASE   = sc_game_pkg::STEP_BASE_DEFAULT,
  parameter int STEP_DEC    = sc_game_pkg::STEP_DEC_DEFAULT,
  parameter int LOCK_TICKS  = sc_game_pkg::LOCK_TICKS_DEFAULT
) (
  input  logic                   SC_COUNTER_CLOCK_50,
  input  logic                   SC_COUNTER_RESET_InLow,
  input  logic                   SC_GOV_tick_InLow,
  input  logic                   SC_GOV_start_InLow,
  input  logic                   SC_GOV_accel_InLow,
  input  logic                   SC_GOV_brake_InLow,
  input  logic                   SC_GOV_crash_InHigh,
  output logic                   SC_GOV_count_OutLow,
  output logic                   SC_GOV_step_OutHigh,
  output logic [LEVEL_WIDTH-1:0] SC_GOV_level_OutBUS,
  output logic [1:0]             SC_GOV_state_OutBUS
);
  import sc_game_pkg::*;

  localparam int                     LOCK_WIDTH = $clog2(LOCK_TICKS + 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_TOP  = '1;
  localparam logic [LOCK_WIDTH-1:0]  LOCK_LOAD  = LOCK_WIDTH'(LOCK_TICKS);
  localparam logic [LOCK_WIDTH-1:0]  LOCK_LAST  = LOCK_WIDTH'(1);

  sc_state_e              state_reg, state_next;
  logic [LEVEL_WIDTH-1:0] level_reg, level_next;
  logic [LOCK_WIDTH-1:0]  lock_reg, lock_next;
  logic                   tick;
  logic                   div_enable, div_clear;
  logic [STEP_WIDTH-1:0]  level_ext, period;

  assign tick = ~SC_GOV_tick_InLow;

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    lock_next  = lock_reg;
    case (state_reg)
      ST_IDLE: begin
        level_next = '0;
        if (!SC_GOV_start_InLow) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (SC_GOV_crash_InHigh) begin
          state_next = ST_CRASH;
          level_next = '0;
          lock_next  = LOCK_LOAD;
        end else if (tick) begin
          // brake has priority over accel when both are held
          if (!SC_GOV_brake_InLow) begin
            if (level_reg != '0) level_next = level_reg - LEVEL_WIDTH'(1);
          end else if (!SC_GOV_accel_InLow) begin
            if (level_reg != LEVEL_TOP) level_next = level_reg + LEVEL_WIDTH'(1);
          end
        end
      end
      ST_CRASH: begin
        level_next = '0;
        // a fresh collision reloads the lockout even on what would be the final tick
        if (SC_GOV_crash_InHigh) begin
          lock_next = LOCK_LOAD;
        end else if (tick) begin
          if (lock_reg == LOCK_LAST) begin
            state_next = ST_RUN;
            lock_next  = '0;
          end else begin
            lock_next = lock_reg - LOCK_WIDTH'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        level_next = '0;
        lock_next  = '0;
      end
    endcase
  end

  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      state_reg <= ST_IDLE;
      level_reg <= '0;
      lock_reg  <= '0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      lock_reg  <= lock_next;
    end
  end

  // Clearing on the edge that changes level/state restarts the period for the new level.
  assign level_ext  = STEP_WIDTH'(level_reg);
  assign period     = STEP_WIDTH'(STEP_BASE)
                    - (level_ext - STEP_WIDTH'(1)) * STEP_WIDTH'(STEP_DEC);
  assign div_enable = (state_reg == ST_RUN) && (level_reg != '0);
  assign div_clear  = (state_next != state_reg) || (level_next != level_reg);

  sc_step_divider #(
    .STEP_WIDTH(STEP_WIDTH)
  ) u_step_divider (
    .SC_COUNTER_CLOCK_50   (SC_COUNTER_CLOCK_50),
    .SC_COUNTER_RESET_InLow(SC_COUNTER_RESET_InLow),
    .period                (period),
    .enable                (div_enable),
    .clear                 (div_clear),
    .step                  (SC_GOV_step_OutHigh)
  );

  always_comb begin
    SC_GOV_count_OutLow = (state_reg == ST_IDLE);
    SC_GOV_level_OutBUS = level_reg;
    SC_GOV_state_OutBUS = state_reg;
  end

endmodule
